rr_pwm_out: RTL

Downstream consumer of the `rr` subsystem's 8-bit PIO output port: turns the software-written byte into a glitch-free PWM waveform for an LED or actuator driver. It latches the target duty every clock and applies it only at period boundaries, optionally slew-limited. It publishes the active duty and a period strobe for monitoring.

---
 rtl/rr_pwm_pkg.sv | 24 ++
 rtl/rr_pwm_prescaler.sv | 28 ++
 rtl/rr_pwm_out.sv | 77 +++++++
 3 files changed

// File: rtl/rr_pwm_pkg.sv
// rr_pwm_pkg: shared widths, FSM states and duty-ramp helper for rr_pwm_out.
package rr_pwm_pkg;

    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] CNT_MAX = 8'd254;

    typedef enum logic {IDLE, RUN} state_t;

    // Move active toward target by at most step. The 9-bit working width
    // keeps the intermediate sum/difference from wrapping past the target.
    function automatic logic [DUTY_W-1:0] ramp_next(
        input logic [DUTY_W-1:0] active,
        input logic [DUTY_W-1:0] target,
        input logic [DUTY_W-1:0] step
    );
        logic [DUTY_W:0] a, t, d;
        a = {1'b0, active};
        t = {1'b0, target};
        d = (t >= a) ? t - a : a - t;
        d = (d > {1'b0, step}) ? {1'b0, step} : d;
        return (t >= a) ? DUTY_W'(a + d) : DUTY_W'(a - d);
    endfunction

endpackage

// File: rtl/rr_pwm_prescaler.sv
// rr_pwm_prescaler: divides clk into one-cycle count ticks every PRESCALE clocks.
//   clk     - system clock
//   reset_n - asynchronous active-low reset
//   clear   - synchronous restart of the division from zero
//   tick    - high in the last clock of each PRESCALE-clock interval
module rr_pwm_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    logic [W-1:0] presc;

    // With PRESCALE=1 presc is pinned at zero, so tick is constantly high.
    assign tick = presc == W'(PRESCALE - 1);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            presc <= '0;
        else
            presc <= (clear || tick) ? '0 : presc + 1'b1;

endmodule

// File: rtl/rr_pwm_out.sv
// rr_pwm_out: glitch-free PWM from the PIO duty byte, updated only at period boundaries.
//   clk         - system clock
//   reset_n     - asynchronous active-low reset
//   enable      - run/stop; stopping abandons the current period
//   duty_in     - target duty, registered every clock
//   pwm_out     - registered PWM waveform
//   period_tick - one-cycle pulse after each completed period
//   duty_active - duty applied in the current period
//   at_target   - duty_active equals the registered target
module rr_pwm_out
    import rr_pwm_pkg::*;
#(
    parameter int PRESCALE  = 4,
    parameter int RAMP_EN   = 1,
    parameter int RAMP_STEP = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_in,
    output logic              pwm_out,
    output logic              period_tick,
    output logic [DUTY_W-1:0] duty_active,
    output logic              at_target
);

    state_t            state, state_next;
    logic              run, tick, boundary;
    logic [DUTY_W-1:0] cnt, duty_target;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (enable) state_next = RUN;
            RUN:  if (!enable) state_next = IDLE;
        endcase
    end

    // Counting follows the state being entered, so a falling enable wins
    // over a coincident boundary and clears the counters on that same edge.
    assign run       = state_next == RUN;
    assign boundary  = run && tick && cnt == CNT_MAX;
    assign at_target = duty_active == duty_target;

    rr_pwm_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!run),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt         <= '0;
            duty_target <= '0;
            duty_active <= '0;
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            duty_target <= duty_in;
            cnt         <= !run ? '0 : !tick ? cnt : (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            period_tick <= boundary;
            pwm_out     <= run && (cnt < duty_active);
            // duty_target here is still last cycle's value, so a write landing
            // in the boundary cycle waits for the next period.
            if (boundary)
                duty_active <= (RAMP_EN != 0) ? ramp_next(duty_active, duty_target, DUTY_W'(RAMP_STEP))
                                              : duty_target;
        end

endmodule
